// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin line arbiter between the instruction fetch path (I)
// and the data cache (D). It shares a single physical-memory line port between them.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_read, i_address         I-side line read request (held until i_resp)
//   i_resp, i_rdata           I-side completion pulse and read line
//   d_read, d_write           D-side line read / writeback request (held until d_resp)
//   d_address, d_wdata        D-side address and writeback line
//   d_resp, d_rdata           D-side completion pulse and read line
//   pmem_read, pmem_write     physical-memory command (decoded from state only)
//   pmem_address, pmem_wdata  physical-memory address / write line
//   pmem_resp, pmem_rdata     physical-memory completion pulse and read line
//
// States:
//   IDLE    | no transaction in flight, arbitrate pending requests
//   SERVE_I | latched I read in flight on pmem
//   SERVE_D | latched D read or write in flight on pmem
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t            state;
  logic              last_grant;  // 0 = I, 1 = D
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic              lat_we;

  logic i_pend;
  logic d_pend;
  logic grant_d;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  // D wins when it is alone, or on a tie when I had the previous grant.
  assign grant_d = d_pend && (!i_pend || !last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_pend || d_pend) begin
            last_grant <= grant_d;
            if (grant_d) begin
              lat_addr  <= d_address;
              lat_wdata <= d_wdata;
              // A simultaneous read+write is treated as a writeback.
              lat_we    <= d_write;
              state     <= SERVE_D;
            end else begin
              lat_addr <= i_address;
              lat_we   <= 1'b0;
              state    <= SERVE_I;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // pmem command depends only on state and latched registers.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = lat_addr;
      end
      SERVE_D: begin
        pmem_read    = !lat_we;
        pmem_write   = lat_we;
        pmem_address = lat_addr;
        pmem_wdata   = lat_wdata;
      end
      default: ;
    endcase
  end

  // Responses pass straight through, gated to the side holding the grant.
  // Reset suppresses them so an abandoned transaction never completes.
  assign i_resp  = (state == SERVE_I) && pmem_resp && !rst;
  assign d_resp  = (state == SERVE_D) && pmem_resp && !rst;
  assign i_rdata = i_resp ? pmem_rdata : '0;
  assign d_rdata = (d_resp && !lat_we) ? pmem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int MEM_LAT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_read, d_read, d_write;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic [AW-1:0] pmem_address;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  int   total = 0;
  int   bad = 0;
  logic mem_auto = 1'b1;
  int   spur_cnt = 0;

  typedef struct {
    logic          side;
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  typedef struct {
    logic          got;
    logic          side;
    logic          both;
    logic          rd;
    logic          wr;
    int            fc;
    int            at;
    logic [LW-1:0] rdata;
    logic [LW-1:0] wdata;
    logic [AW-1:0] addr;
  } obs_t;

  exp_t exp_q[$];

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    if (a == 32'h0000_0100) return {32{8'hA5}};
    return {8{a ^ 32'h3C3C_0F0F}};
  endfunction

  // Memory model: responds on the (MEM_LAT+1)th cycle of a held command.
  initial begin : mem_model
    int cnt;
    int spur_seen;
    cnt = 0;
    spur_seen = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        cnt = 0;
      end else if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        pmem_resp = 1'b1;
        pmem_rdata = {32{8'hEE}};
      end else if ((pmem_read || pmem_write) && mem_auto) begin
        cnt++;
        if (cnt > MEM_LAT) begin
          pmem_resp = 1'b1;
          pmem_rdata = pmem_read ? line_of(pmem_address) : {32{8'h77}};
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic push_exp(input logic side, input logic we, input logic [AW-1:0] addr,
                          input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    exp_t e;
    e.side = side; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic pop_exp(output exp_t e, output logic ok);
    ok = (exp_q.size() > 0);
    e.side = 1'b0; e.we = 1'b0; e.addr = '0; e.wdata = '0; e.rdata = '0;
    if (ok) e = exp_q.pop_front();
  endtask

  // Steps negedges until a response appears; observes only, never judges.
  task automatic wait_resp(input int budget, output obs_t o);
    o.got = 0; o.side = 0; o.both = 0; o.rd = 0; o.wr = 0; o.fc = -1; o.at = -1;
    o.rdata = '0; o.wdata = '0; o.addr = '0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if ((pmem_read || pmem_write) && o.fc < 0) o.fc = k;
      if (i_resp || d_resp) begin
        o.got = 1; o.side = d_resp; o.both = i_resp && d_resp; o.at = k;
        o.rdata = d_resp ? d_rdata : i_rdata;
        o.rd = pmem_read; o.wr = pmem_write; o.addr = pmem_address; o.wdata = pmem_wdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_read = 1'b1; i_address = 32'h40; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0;
    @(negedge clk); @(negedge clk);
    total++; if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b want=0000", {i_resp, d_resp, pmem_read, pmem_write}); end
    total++; if (pmem_address !== '0) begin bad++;
      $display("FAIL reset_addr got=%h want=0", pmem_address); end
    total++; if ((pmem_wdata | i_rdata | d_rdata) !== '0) begin bad++;
      $display("FAIL reset_data got=%h want=0", pmem_wdata | i_rdata | d_rdata); end
    rst = 1'b0; i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_i();
    obs_t o; exp_t e; logic ok;
    @(negedge clk);
    i_read = 1; i_address = 32'h0000_0100;
    push_exp(0, 0, 32'h0000_0100, '0, {32{8'hA5}});
    wait_resp(40, o);
    i_read = 0;
    pop_exp(e, ok);
    total++; if (!o.got || !ok) begin bad++; $display("FAIL single_i_timeout got=%b sb=%b want=1", o.got, ok); end
    else begin
      total++; if (o.side !== e.side) begin bad++; $display("FAIL single_i_side got=%b want=%b", o.side, e.side); end
      total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL single_i_rdata got=%h want=%h", o.rdata, e.rdata); end
      total++; if ({o.rd, o.wr, o.addr} !== {1'b1, 1'b0, e.addr}) begin bad++;
        $display("FAIL single_i_cmd got=%b%b/%h want=10/%h", o.rd, o.wr, o.addr, e.addr); end
      total++; if (o.fc !== 1 || o.at !== 6) begin bad++;
        $display("FAIL single_i_timing got=first%0d resp%0d want=first1 resp6", o.fc, o.at); end
      total++; if (o.both !== 1'b0) begin bad++; $display("FAIL single_i_both got=1 want=0"); end
    end
    @(negedge clk);
    total++; if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0) begin bad++;
      $display("FAIL single_i_after got=%b want=0000", {pmem_read, pmem_write, i_resp, d_resp}); end
  endtask

  task automatic test_d_write(input logic both_flags, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    obs_t o; exp_t e; logic ok;
    @(negedge clk);
    d_write = 1; d_read = both_flags; d_address = a; d_wdata = wd;
    push_exp(1, 1, a, wd, '0);
    wait_resp(40, o);
    d_write = 0; d_read = 0;
    pop_exp(e, ok);
    total++; if (!o.got || !ok) begin bad++; $display("FAIL d_write_timeout got=%b sb=%b want=1", o.got, ok); end
    else begin
      total++; if (o.side !== e.side) begin bad++; $display("FAIL d_write_side got=%b want=%b", o.side, e.side); end
      total++; if (o.rdata !== e.rdata) begin bad++; $display("FAIL d_write_rdata got=%h want=%h", o.rdata, e.rdata); end
      total++; if ({o.rd, o.wr, o.addr} !== {1'b0, 1'b1, e.addr}) begin bad++;
        $display("FAIL d_write_cmd got=%b%b/%h want=01/%h", o.rd, o.wr, o.addr, e.addr); end
      total++; if (o.wdata !== e.wdata) begin bad++; $display("FAIL d_write_wdata got=%h want=%h", o.wdata, e.wdata); end
      total++; if (o.fc !== 1) begin bad++; $display("FAIL d_write_latency got=%0d want=1", o.fc); end
    end
    @(negedge clk);
    total++; if ({pmem_read, pmem_write} !== 2'b0) begin bad++;
      $display("FAIL d_write_after got=%b want=00", {pmem_read, pmem_write}); end
  endtask

  task automatic test_fairness();
    obs_t o; exp_t e; logic ok;
    logic [AW-1:0] ia;
    ia = 32'h400;
    rst = 1; @(negedge clk); @(negedge clk); rst = 0;
    i_read = 1; i_address = ia; d_read = 1; d_address = 32'h3000;
    push_exp(0, 0, ia, '0, line_of(ia));
    push_exp(1, 0, 32'h3000, '0, line_of(32'h3000));
    for (int r = 0; r < 4; r++) begin
      wait_resp(40, o);
      pop_exp(e, ok);
      total++; if (!o.got || !ok) begin bad++; $display("FAIL fair_timeout round=%0d got=%b sb=%b want=1", r, o.got, ok); end
      else begin
        total++; if (o.side !== e.side) begin bad++; $display("FAIL fair_order round=%0d got=%b want=%b", r, o.side, e.side); end
        total++; if (o.rdata !== e.rdata || o.addr !== e.addr) begin bad++;
          $display("FAIL fair_data round=%0d got=%h@%h want=%h@%h", r, o.rdata, o.addr, e.rdata, e.addr); end
        total++; if (o.both !== 1'b0) begin bad++; $display("FAIL fair_both round=%0d got=1 want=0", r); end
        if (r > 0) begin
          total++; if (o.fc !== 2) begin bad++; $display("FAIL fair_turnaround round=%0d got=%0d want=2", r, o.fc); end
        end
        if (o.side == 1'b0) begin
          ia = ia + 32'h100; i_address = ia;
          if (r < 2) push_exp(0, 0, ia, '0, line_of(ia));
          else i_read = 0;
        end else begin
          if (r < 2) push_exp(1, 0, 32'h3000, '0, line_of(32'h3000));
          else d_read = 0;
        end
      end
    end
    i_read = 0; d_read = 0;
  endtask

  task automatic test_mid_request();
    obs_t o; exp_t e; logic ok;
    @(negedge clk);
    d_read = 1; d_address = 32'h5000;
    push_exp(1, 0, 32'h5000, '0, line_of(32'h5000));
    @(negedge clk); @(negedge clk);
    i_read = 1; i_address = 32'h600;
    push_exp(0, 0, 32'h700, '0, line_of(32'h700));
    @(negedge clk);
    total++; if (i_resp !== 1'b0 || pmem_address !== 32'h5000) begin bad++;
      $display("FAIL mid_hold got=%b/%h want=0/00005000", i_resp, pmem_address); end
    i_address = 32'h700;
    for (int r = 0; r < 2; r++) begin
      wait_resp(40, o);
      pop_exp(e, ok);
      if (o.side == 1'b1) d_read = 0; else i_read = 0;
      total++; if (!o.got || !ok) begin bad++; $display("FAIL mid_timeout step=%0d got=%b sb=%b want=1", r, o.got, ok); end
      else begin
        total++; if (o.side !== e.side) begin bad++; $display("FAIL mid_side step=%0d got=%b want=%b", r, o.side, e.side); end
        total++; if (o.rdata !== e.rdata || o.addr !== e.addr) begin bad++;
          $display("FAIL mid_data step=%0d got=%h@%h want=%h@%h", r, o.rdata, o.addr, e.rdata, e.addr); end
        if (r == 1) begin
          total++; if (o.fc !== 2) begin bad++; $display("FAIL mid_grant got=%0d want=2", o.fc); end
        end
      end
    end
    i_read = 0; d_read = 0;
  endtask

  task automatic test_prefetch_chain();
    obs_t o; exp_t e; logic ok;
    @(negedge clk);
    i_read = 1; i_address = 32'h8000;
    push_exp(0, 0, 32'h8000, '0, line_of(32'h8000));
    push_exp(0, 0, 32'h8100, '0, line_of(32'h8100));
    for (int r = 0; r < 2; r++) begin
      wait_resp(40, o);
      pop_exp(e, ok);
      if (r == 0) i_address = 32'h8100; else i_read = 0;
      total++; if (!o.got || !ok) begin bad++; $display("FAIL chain_timeout step=%0d got=%b sb=%b want=1", r, o.got, ok); end
      else begin
        total++; if (o.side !== e.side || o.rdata !== e.rdata || o.addr !== e.addr) begin bad++;
          $display("FAIL chain_data step=%0d got=%b:%h@%h want=%b:%h@%h", r, o.side, o.rdata, o.addr, e.side, e.rdata, e.addr); end
        if (r == 1) begin
          total++; if (o.fc !== 2) begin bad++; $display("FAIL chain_gap got=%0d want=2", o.fc); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t e; logic ok;
    @(negedge clk);
    mem_auto = 0;
    d_read = 1; d_address = 32'h9000;
    @(negedge clk); @(negedge clk); @(negedge clk);
    total++; if (pmem_read !== 1'b1 || pmem_address !== 32'h9000) begin bad++;
      $display("FAIL rmid_active got=%b/%h want=1/00009000", pmem_read, pmem_address); end
    rst = 1; d_read = 0;
    @(negedge clk);
    rst = 0;
    total++; if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0 || pmem_address !== '0) begin bad++;
      $display("FAIL rmid_clear got=%b/%h want=0000/0", {i_resp, d_resp, pmem_read, pmem_write}, pmem_address); end
    total++; if ((pmem_wdata | i_rdata | d_rdata) !== '0) begin bad++;
      $display("FAIL rmid_data got=%h want=0", pmem_wdata | i_rdata | d_rdata); end
    mem_auto = 1;
    spur_cnt++;
    @(negedge clk);
    total++; if ({pmem_resp, i_resp, d_resp} !== 3'b100 || (i_rdata | d_rdata) !== '0) begin bad++;
      $display("FAIL rmid_spurious got=%b/%h want=100/0", {pmem_resp, i_resp, d_resp}, i_rdata | d_rdata); end
    @(negedge clk);
    total++; if ({pmem_read, pmem_write} !== 2'b0) begin bad++;
      $display("FAIL rmid_idle got=%b want=00", {pmem_read, pmem_write}); end
    i_read = 1; i_address = 32'hA000;
    push_exp(0, 0, 32'hA000, '0, line_of(32'hA000));
    wait_resp(40, o);
    i_read = 0;
    pop_exp(e, ok);
    total++; if (!o.got || !ok) begin bad++; $display("FAIL rmid_fresh_timeout got=%b sb=%b want=1", o.got, ok); end
    else begin
      total++; if (o.side !== e.side || o.rdata !== e.rdata || o.addr !== e.addr || o.fc !== 1) begin bad++;
        $display("FAIL rmid_fresh got=%b:%h@%h first%0d want=%b:%h@%h first1", o.side, o.rdata, o.addr, o.fc, e.side, e.rdata, e.addr); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1; i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0;
    test_reset();
    test_single_i();
    test_d_write(1'b0, 32'h0000_2000, {8{32'h1234_5678}});
    test_d_write(1'b1, 32'h0000_2100, {8{32'hDEAD_BEEF}});
    test_fairness();
    test_mid_request();
    test_prefetch_chain();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port line arbiter between the instruction-side fetch path (prefetch unit) and the data cache on one side, and the single physical-memory line port on the other. It is the responder for the instruction-side line-read handshake and for the data-side line read/write handshake. It grants one requester at a time with round-robin priority, latches the granted request, and drives it to physical memory. It routes the memory response back to the granted side only.

## Interface
Parameters:
- ADDR_W, 32, address width in bits.
- LINE_W, 256, cache-line width in bits.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- i_read  in  1  instruction-side line read request; held until i_resp.
- i_address  in  ADDR_W  instruction-side line address; stable while i_read.
- i_resp  out  1  one-cycle completion pulse to instruction side.
- i_rdata  out  LINE_W  read line; valid only when i_resp, else 0.
- d_read  in  1  data-side line read request; held until d_resp.
- d_write  in  1  data-side line write request (writeback); held until d_resp.
- d_address  in  ADDR_W  data-side line address; stable while d_read or d_write.
- d_wdata  in  LINE_W  writeback line; stable while d_write.
- d_resp  out  1  one-cycle completion pulse to data side (read or write).
- d_rdata  out  LINE_W  read line; valid only when d_resp on a read, else 0.
- pmem_read  out  1  physical-memory line read.
- pmem_write  out  1  physical-memory line write.
- pmem_address  out  ADDR_W  physical-memory address.
- pmem_wdata  out  LINE_W  physical-memory write data.
- pmem_resp  in  1  physical-memory completion pulse.
- pmem_rdata  in  LINE_W  physical-memory read line; valid with pmem_resp.

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- Registers:
  - state.
  - last_grant (0 = I, 1 = D).
  - lat_addr.
  - lat_wdata.
  - lat_we.
- IDLE, with the pending set computed as i_read for I and (d_read | d_write) for D:
  - Neither pending: stay in IDLE.
  - Only one pending: grant that side.
  - Both pending: grant the side opposite last_grant.
  - On a grant, latch the address. For a D grant, also latch d_wdata and lat_we = d_write.
  - Set last_grant to the granted side and move to SERVE_I or SERVE_D.
- If d_read and d_write are asserted together, the request is illegal. The arbiter treats it as a write.
- SERVE_I:
  - pmem_read = 1, pmem_address = lat_addr.
  - When pmem_resp arrives: i_resp = 1, i_rdata = pmem_rdata, next state IDLE.
- SERVE_D:
  - pmem_read = !lat_we, pmem_write = lat_we, pmem_address = lat_addr, pmem_wdata = lat_wdata.
  - When pmem_resp arrives: d_resp = 1, d_rdata = pmem_rdata if read, else 0. Next state IDLE.
- pmem_read and pmem_write are decoded only from state and latched registers, never combinationally from requester inputs. They are never asserted together.
- Responses are combinational pass-throughs gated by state. Neither side ever sees a resp while the other side holds the grant.
- Request inputs are ignored outside IDLE. A request that arrives or drops mid-service does not disturb the transaction in flight.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (D), so I wins the first tie.
  - All registers 0.
  - All outputs 0: i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata.
- Reset mid-transaction: state goes to IDLE on that edge and pmem_* drop the next cycle. The in-flight transaction is abandoned and no resp is produced.
- Grant latency: a request sampled in IDLE at cycle N gives pmem_read or pmem_write asserted in cycle N+1.
- Response latency: resp appears in the same cycle as pmem_resp (zero added latency).
- Turnaround: after pmem_resp the arbiter spends exactly one cycle in IDLE, with pmem_read and pmem_write = 0. A requester re-asserting immediately (e.g. the prefetcher chaining a miss into a prefetch) is granted in that IDLE cycle. Its pmem command starts in the following cycle.
- Back-to-back minimum: 1 idle cycle between consecutive pmem transactions. Best-case total is pmem latency + 2 cycles per request.
- Fairness: with both sides continuously requesting, grants strictly alternate I, D, I, D. Worst-case wait is one full transaction of the other side.
- pmem_resp while in IDLE is spurious: ignored, no resp generated.

## Test plan
- Single I read, address 0x0000_0100, pmem latency 5 with pmem_rdata = 0xA5..A5 -> pmem_read high cycles 1–6. i_resp one pulse with i_rdata = 0xA5..A5, d_resp stays 0. pmem_read low the following cycle.
- Single D write, address 0x0000_2000, d_wdata = 0x1234…: pmem_write = 1, pmem_read = 0, pmem_wdata and pmem_address match the inputs. d_resp pulses with d_rdata = 0.
- I and D both asserted from reset -> I granted first. After its resp, one idle cycle, then D granted. Four consecutive simultaneous rounds give grant order I, D, I, D.
- D read in progress while i_read rises mid-transaction -> no i_resp until the D resp completes. I is granted in the next IDLE cycle. Changing i_address during D service does not alter pmem_address.
- Prefetcher chain: i_read held through resp and re-asserted with address + 0x100 -> the second pmem_read starts exactly 2 cycles after the first pmem_resp, at the new address.
- rst asserted for one cycle mid SERVE_D -> all outputs 0 the next cycle, no d_resp. A late pmem_resp arriving in IDLE is ignored, and a fresh I request is then served normally.
